// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared fu_op encodings, legality check and response entry type for the multiplier arbiter
package mult_share_pkg;

  localparam int OP_W      = 6;
  localparam int DEF_XLEN  = 64;
  localparam int DEF_TID_W = 3;

  typedef enum logic [OP_W-1:0] {
    FU_MUL    = 6'h20,
    FU_MULH   = 6'h21,
    FU_MULHSU = 6'h22,
    FU_MULHU  = 6'h23,
    FU_MULW   = 6'h24,
    FU_CLMUL  = 6'h28,
    FU_CLMULH = 6'h29,
    FU_CLMULR = 6'h2a
  } fu_op_e;

  typedef struct packed {
    logic [DEF_XLEN-1:0]  result;
    logic [DEF_TID_W-1:0] tid;
  } rsp_entry_t;

  function automatic logic is_mult_op(logic [OP_W-1:0] op);
    case (op)
      FU_MUL, FU_MULH, FU_MULHSU, FU_MULHU, FU_MULW,
      FU_CLMUL, FU_CLMULH, FU_CLMULR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mult_share_rsp_fifo.sv
// rtl/mult_share_rsp_fifo.sv - per-requester response FIFO; head is read from storage, last popped value held when empty
module mult_share_rsp_fifo
  import mult_share_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = rsp_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output logic   valid_o,
  output entry_t data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  entry_t           hold_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: it is only observed while count_q says it is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin, credit-gated sharing of one 1-cycle multiplier among NUM_REQ requesters
// Optional perf counters: MULT_SHARE_ARB_PERF_EN
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int XLEN      = 64,
  parameter int TID_W     = 3,
  parameter int RSP_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]  req_op_i,
  input  logic [NUM_REQ*XLEN-1:0]  req_a_i,
  input  logic [NUM_REQ*XLEN-1:0]  req_b_i,
  input  logic [NUM_REQ*TID_W-1:0] req_tid_i,
  output logic                     mul_valid_o,
  output logic [OP_W-1:0]          mul_op_o,
  output logic [XLEN-1:0]          mul_a_o,
  output logic [XLEN-1:0]          mul_b_o,
  output logic [TID_W-1:0]         mul_tid_o,
  input  logic                     mul_valid_i,
  input  logic [XLEN-1:0]          mul_result_i,
  input  logic [TID_W-1:0]         mul_tid_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [NUM_REQ*XLEN-1:0]  rsp_result_o,
  output logic [NUM_REQ*TID_W-1:0] rsp_tid_o
`ifdef MULT_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]              perf_issue_o,
  output logic [31:0]              perf_stall_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TID_W-1:0] tid;
  } rsp_t;

  logic [IDX_W-1:0]   ptr_q;
  logic [CRD_W-1:0]   credit_q [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   cidx;
  logic               any_grant;
  int                 cand;
  logic [OP_W-1:0]    gnt_op;
  logic               gnt_legal;

  logic               vld_q;
  logic               illegal_q;
  logic [IDX_W-1:0]   src_q;
  logic [TID_W-1:0]   tid_q;

  rsp_t               push_data;
  rsp_t               fifo_data [NUM_REQ];

  // Credit is sampled before any same-cycle pop, so a pop only frees a slot next cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (credit_q[i] != '0);
    end
  end

  always_comb begin
    grant     = '0;
    gidx      = '0;
    cidx      = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cidx = IDX_W'(cand);
      if (!any_grant && elig[cidx]) begin
        grant[cidx] = 1'b1;
        gidx        = cidx;
        any_grant   = 1'b1;
      end
    end
  end

  assign req_ready_o = grant;
  assign gnt_op      = req_op_i[gidx*OP_W +: OP_W];
  assign gnt_legal   = is_mult_op(gnt_op);

  assign mul_valid_o = any_grant && gnt_legal;
  assign mul_op_o    = any_grant ? gnt_op : '0;
  assign mul_a_o     = any_grant ? req_a_i[gidx*XLEN +: XLEN] : '0;
  assign mul_b_o     = any_grant ? req_b_i[gidx*XLEN +: XLEN] : '0;
  assign mul_tid_o   = any_grant ? req_tid_i[gidx*TID_W +: TID_W] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      vld_q     <= 1'b0;
      illegal_q <= 1'b0;
      src_q     <= '0;
      tid_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= CRD_W'(RSP_DEPTH);
      end
    end else begin
      vld_q     <= any_grant;
      illegal_q <= any_grant && !gnt_legal;
      src_q     <= gidx;
      tid_q     <= mul_tid_o;
      if (any_grant) begin
        ptr_q <= gidx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], pop[i]})
          2'b10:   credit_q[i] <= credit_q[i] - CRD_W'(1);
          2'b01:   credit_q[i] <= credit_q[i] + CRD_W'(1);
          default: credit_q[i] <= credit_q[i];
        endcase
      end
    end
  end

  // Illegal ops never reach the multiplier but still return a zero result in order.
  assign push_data.result = illegal_q ? '0 : mul_result_i;
  assign push_data.tid    = tid_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      push[i] = vld_q && (src_q == IDX_W'(i));
      pop[i]  = rsp_valid_o[i] && rsp_ready_i[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    mult_share_rsp_fifo #(
      .DEPTH   (RSP_DEPTH),
      .entry_t (rsp_t)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push[g]),
      .push_data_i (push_data),
      .pop_i       (rsp_ready_i[g]),
      .valid_o     (rsp_valid_o[g]),
      .data_o      (fifo_data[g])
    );
    assign rsp_result_o[g*XLEN +: XLEN]  = fifo_data[g].result;
    assign rsp_tid_o[g*TID_W +: TID_W]   = fifo_data[g].tid;
  end

`ifdef MULT_SHARE_ARB_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (any_grant) begin
        perf_issue_q <= perf_issue_q + 32'd1;
      end
      if ((|req_valid_i) && !any_grant) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_stall_o = perf_stall_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (mul_valid_i == (vld_q && !illegal_q));
      if (mul_valid_i) begin
        assert (mul_tid_i == tid_q);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (credit_q[i] <= CRD_W'(RSP_DEPTH));
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - scoreboard bench for mult_share_arbiter with a 1-cycle multiplier model
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_valid_i;
  logic [1:0]   req_ready_o;
  logic [11:0]  req_op_i;
  logic [127:0] req_a_i;
  logic [127:0] req_b_i;
  logic [5:0]   req_tid_i;
  logic         mul_valid_o;
  logic [5:0]   mul_op_o;
  logic [63:0]  mul_a_o;
  logic [63:0]  mul_b_o;
  logic [2:0]   mul_tid_o;
  logic         mul_valid_i;
  logic [63:0]  mul_result_i;
  logic [2:0]   mul_tid_i;
  logic [1:0]   rsp_valid_o;
  logic [1:0]   rsp_ready_i;
  logic [127:0] rsp_result_o;
  logic [5:0]   rsp_tid_o;
`ifdef MULT_SHARE_ARB_PERF_EN
  logic [31:0]  perf_issue_o;
  logic [31:0]  perf_stall_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr;
  int exp_cred [2];
  int dut_gnt  [2];
  int hs_cnt;
  int stall_cnt;
  logic [66:0] sb0 [$];
  logic [66:0] sb1 [$];

  mult_share_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_tid_i    (req_tid_i),
    .mul_valid_o  (mul_valid_o),
    .mul_op_o     (mul_op_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_tid_o    (mul_tid_o),
    .mul_valid_i  (mul_valid_i),
    .mul_result_i (mul_result_i),
    .mul_tid_i    (mul_tid_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_tid_o    (rsp_tid_o)
`ifdef MULT_SHARE_ARB_PERF_EN
    ,
    .perf_issue_o (perf_issue_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] golden(logic [5:0] op, logic [63:0] a, logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p, cl;
    logic [31:0]  w;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    cl = '0;
    for (int i = 0; i < 64; i++) if (b[i]) cl = cl ^ (ua << i);
    w = a[31:0] * b[31:0];
    case (op)
      FU_MUL:    begin p = ua * ub; return p[63:0];   end
      FU_MULH:   begin p = sa * sb; return p[127:64]; end
      FU_MULHU:  begin p = ua * ub; return p[127:64]; end
      FU_MULHSU: begin p = sa * ub; return p[127:64]; end
      FU_MULW:   return {{32{w[31]}}, w};
      FU_CLMUL:  return cl[63:0];
      FU_CLMULH: return cl[127:64];
      FU_CLMULR: return cl[126:63];
      default:   return 64'd0;
    endcase
  endfunction

  function automatic logic [5:0] pick_op(int k);
    case (k % 8)
      0: return FU_MUL;
      1: return FU_MULH;
      2: return FU_MULHU;
      3: return FU_MULHSU;
      4: return FU_MULW;
      5: return FU_CLMUL;
      6: return FU_CLMULH;
      default: return FU_CLMULR;
    endcase
  endfunction

  // Multiplier: one register stage, shares the arbiter reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mul_valid_i  <= 1'b0;
      mul_result_i <= '0;
      mul_tid_i    <= '0;
    end else begin
      mul_valid_i  <= mul_valid_o;
      mul_result_i <= golden(mul_op_o, mul_a_o, mul_b_o);
      mul_tid_i    <= mul_tid_o;
    end
  end

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(int i, logic [5:0] op, logic [63:0] a, logic [63:0] b, logic [2:0] tid);
    req_op_i[i*6 +: 6]   = op;
    req_a_i[i*64 +: 64]  = a;
    req_b_i[i*64 +: 64]  = b;
    req_tid_i[i*3 +: 3]  = tid;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic [1:0]  exp_rdy;
    logic        found;
    logic [66:0] e;
    logic [5:0]  op;
    int          c;
    #1;
    exp_rdy = '0;
    found   = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      c = (exp_ptr + k) % 2;
      if (!found && req_valid_i[c] && exp_cred[c] > 0) begin
        exp_rdy[c] = 1'b1;
        found      = 1'b1;
      end
    end
    check_eq("grant", {62'd0, req_ready_o}, {62'd0, exp_rdy});
    if (|req_valid_i && !found) stall_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (req_ready_o[i]) dut_gnt[i]++;
      if (exp_rdy[i]) begin
        exp_cred[i]--;
        exp_ptr = i;
        hs_cnt++;
        op = req_op_i[i*6 +: 6];
        e  = {is_mult_op(op) ? golden(op, req_a_i[i*64 +: 64], req_b_i[i*64 +: 64]) : 64'd0,
              req_tid_i[i*3 +: 3]};
        if (i == 0) sb0.push_back(e); else sb1.push_back(e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_o[i] && rsp_ready_i[i]) begin
        exp_cred[i]++;
        if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
          check_eq("rsp_unexpected", {63'd0, rsp_valid_o[i]}, 64'd0);
        end else begin
          e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          check_eq("rsp_result", rsp_result_o[i*64 +: 64], e[66:3]);
          check_eq("rsp_tid", {61'd0, rsp_tid_o[i*3 +: 3]}, {61'd0, e[2:0]});
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    #1;
    check_eq("rst_rsp_valid", {62'd0, rsp_valid_o}, 64'd0);
    check_eq("rst_rsp_result", rsp_result_o[63:0] | rsp_result_o[127:64], 64'd0);
    check_eq("rst_rsp_tid", {58'd0, rsp_tid_o}, 64'd0);
    check_eq("rst_mul_valid", {63'd0, mul_valid_o}, 64'd0);
    check_eq("rst_mul_a", mul_a_o, 64'd0);
    check_eq("rst_req_ready", {62'd0, req_ready_o}, 64'd0);
`ifdef MULT_SHARE_ARB_PERF_EN
    check_eq("rst_perf_issue", {32'd0, perf_issue_o}, 64'd0);
    check_eq("rst_perf_stall", {32'd0, perf_stall_o}, 64'd0);
`endif
    sb0.delete();
    sb1.delete();
    exp_ptr     = 1;
    exp_cred[0] = 2;
    exp_cred[1] = 2;
    hs_cnt      = 0;
    stall_cnt   = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int g0;
    req_op_i  = '0;
    req_a_i   = '0;
    req_b_i   = '0;
    req_tid_i = '0;
    dut_gnt[0] = 0;
    dut_gnt[1] = 0;
    do_reset();

    // Single MUL: issue same cycle, response two cycles later.
    set_req(0, FU_MUL, 64'd3, 64'd5, 3'd1);
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b11;
    #1;
    check_eq("t1_ready", {62'd0, req_ready_o}, 64'd1);
    check_eq("t1_mul_valid", {63'd0, mul_valid_o}, 64'd1);
    check_eq("t1_mul_a", mul_a_o, 64'd3);
    check_eq("t1_mul_tid", {61'd0, mul_tid_o}, 64'd1);
    tick();
    req_valid_i = 2'b00;
    check_eq("t1_lat_t1", {62'd0, rsp_valid_o}, 64'd0);
    tick();
    check_eq("t1_lat_t2", {63'd0, rsp_valid_o[0]}, 64'd1);
    check_eq("t1_result", rsp_result_o[63:0], 64'd15);
    check_eq("t1_tid", {61'd0, rsp_tid_o[2:0]}, 64'd1);
    tick();

    // Both requesters streaming from reset: strict alternation starting at 0.
    do_reset();
    rsp_ready_i = 2'b11;
    req_valid_i = 2'b11;
    for (int k = 0; k < 10; k++) begin
      set_req(0, pick_op(k), {$urandom, $urandom}, {$urandom, $urandom}, 3'(k));
      set_req(1, pick_op(k + 3), {$urandom, $urandom}, {$urandom, $urandom}, 3'(k + 4));
      #1;
      check_eq("t2_alternate", {62'd0, req_ready_o}, (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    req_valid_i = 2'b00;
    repeat (4) tick();
    check_eq("t2_drained", 64'(sb0.size() + sb1.size()), 64'd0);

    // Requester 0 stops consuming: two accepts, then blocked while 1 keeps going.
    g0 = dut_gnt[0];
    rsp_ready_i = 2'b10;
    req_valid_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_req(0, pick_op(k), {$urandom, $urandom}, {$urandom, $urandom}, 3'(k));
      set_req(1, pick_op(k + 5), {$urandom, $urandom}, {$urandom, $urandom}, 3'(k + 1));
      tick();
    end
    check_eq("t3_req0_accepts", 64'(dut_gnt[0] - g0), 64'd2);
    rsp_ready_i = 2'b11;
    #1;
    check_eq("t3_pop_same_cycle", {63'd0, req_ready_o[0]}, 64'd0);
    tick();
    rsp_ready_i = 2'b10;
    req_valid_i = 2'b01;
    #1;
    check_eq("t3_reenable", {63'd0, req_ready_o[0]}, 64'd1);
    tick();
    check_eq("t3_still_blocked", {63'd0, req_ready_o[0]}, 64'd0);
    tick();
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b11;
    repeat (6) tick();
    check_eq("t3_drained", 64'(sb0.size() + sb1.size()), 64'd0);

    // Illegal op: handshake without multiplier issue, zero result returned.
    set_req(1, 6'h3f, 64'h1234, 64'h5678, 3'd5);
    req_valid_i = 2'b10;
    #1;
    check_eq("t4_ready", {62'd0, req_ready_o}, 64'd2);
    check_eq("t4_mul_valid", {63'd0, mul_valid_o}, 64'd0);
    tick();
    req_valid_i = 2'b00;
    tick();
    check_eq("t4_rsp_valid", {63'd0, rsp_valid_o[1]}, 64'd1);
    check_eq("t4_result", rsp_result_o[127:64], 64'd0);
    check_eq("t4_tid", {61'd0, rsp_tid_o[5:3]}, 64'd5);
    tick();

`ifdef MULT_SHARE_ARB_PERF_EN
    check_eq("perf_issue", {32'd0, perf_issue_o}, 64'(hs_cnt));
    check_eq("perf_stall", {32'd0, perf_stall_o}, 64'(stall_cnt));
`endif

    // Reset with ops in flight and buffered, then verify credits are full again.
    rsp_ready_i = 2'b00;
    req_valid_i = 2'b11;
    set_req(0, FU_MUL, 64'd7, 64'd9, 3'd2);
    set_req(1, FU_CLMUL, 64'd6, 64'd3, 3'd3);
    tick();
    tick();
    do_reset();
    g0 = dut_gnt[0];
    req_valid_i = 2'b01;
    repeat (3) tick();
    check_eq("t5_credit_full", 64'(dut_gnt[0] - g0), 64'd2);
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b11;
    repeat (4) tick();
    check_eq("t5_drained", 64'(sb0.size() + sb1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
